// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter.
// Holds the machine-wide sizes (FU count, word width, reorder-buffer tag width)
// and the NULL tag, which the reservation stations use with the same meaning.
package cdb_arbiter_pkg;

    localparam int unsigned FU_NUM    = 4;
    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned RB_INDEX  = 3;
    localparam int unsigned RB_SIZE   = 2 ** RB_INDEX;
    // Tag meaning "no destination"; a request carrying it is never broadcast.
    localparam int unsigned NULL_TAG  = RB_SIZE - 1;
    localparam int unsigned PTR_W     = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
    localparam int unsigned STALL_W   = 16;

    typedef logic [PTR_W-1:0]     fu_idx_t;
    typedef logic [RB_INDEX-1:0]  rb_tag_t;
    typedef logic [WORD_SIZE-1:0] word_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector, one bit per functional unit
//   ptr     - highest-priority index for this cycle
//   winner  - first set bit of req at or above ptr, wrapping modulo FU_NUM
//   any_req - req has at least one bit set (winner is meaningless otherwise)
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
(
    input  logic [FU_NUM-1:0] req,
    input  fu_idx_t           ptr,
    output fu_idx_t           winner,
    output logic              any_req
);

    int unsigned idx;

    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        idx     = 0;
        // Walk from ptr upward; the first hit wins and later hits are ignored.
        for (int unsigned i = 0; i < FU_NUM; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= FU_NUM) begin
                idx = idx - FU_NUM;
            end
            if (!any_req && req[idx[PTR_W-1:0]]) begin
                winner  = fu_idx_t'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Result-bus arbiter between the functional units and the common data bus.
// Picks one finished FU result per cycle (round-robin), broadcasts it in the
// slot of its reorder-buffer tag, and returns a one-cycle grant to the winner.
// Ports:
//   clk, reset_n    - clock (rising edge), asynchronous active-low reset
//   valid_bus       - bit i: FU i holds a finished result
//   data_bus        - FU i result in [i*WORD_SIZE +: WORD_SIZE]
//   RB_index_bus    - FU i destination tag in [i*RB_INDEX +: RB_INDEX]
//   flush           - synchronous flush; clears the broadcast and resets priority
//   grant           - one-hot acknowledge to the winning FU
//   CDB_data_data   - winner's data in its tag slot, all other slots 0
//   CDB_data_valid  - one-hot valid at the winner's tag
//   null_err        - sticky: some request carried the NULL tag
//   stall_cnt       - saturating count of granting cycles with a losing requester
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [FU_NUM-1:0]             valid_bus,
    input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
    input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
    input  logic                          flush,
    output logic [FU_NUM-1:0]             grant,
    output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    output logic [RB_SIZE-1:0]            CDB_data_valid,
    output logic                          null_err,
    output logic [STALL_W-1:0]            stall_cnt
);

    function automatic word_t fu_data(input logic [FU_NUM*WORD_SIZE-1:0] bus,
                                      input fu_idx_t i);
        return bus[32'(i)*WORD_SIZE +: WORD_SIZE];
    endfunction

    function automatic rb_tag_t fu_tag(input logic [FU_NUM*RB_INDEX-1:0] bus,
                                       input fu_idx_t i);
        return bus[32'(i)*RB_INDEX +: RB_INDEX];
    endfunction

    logic [FU_NUM-1:0]            grant_q, grant_d;
    logic [WORD_SIZE*RB_SIZE-1:0] cdb_data_q, cdb_data_d;
    logic [RB_SIZE-1:0]           cdb_valid_q, cdb_valid_d;
    logic                         null_err_q, null_err_d;
    logic [STALL_W-1:0]           stall_q, stall_d;
    fu_idx_t                      ptr_q, ptr_d;

    logic [FU_NUM-1:0] null_hit;
    logic [FU_NUM-1:0] req;
    fu_idx_t           winner;
    logic              any_req;
    rb_tag_t           win_tag;

    // The FU granted last cycle is still dropping valid, so it is masked to
    // avoid broadcasting the same result twice. NULL-tagged requests never win.
    always_comb begin
        null_hit = '0;
        for (int unsigned i = 0; i < FU_NUM; i++) begin
            null_hit[i] = (fu_tag(RB_index_bus, fu_idx_t'(i)) == rb_tag_t'(NULL_TAG));
        end
        req = valid_bus & ~grant_q & ~null_hit;
    end

    cdb_arbiter_rr_pick u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        grant_d     = '0;
        cdb_valid_d = '0;
        cdb_data_d  = '0;
        ptr_d       = ptr_q;
        stall_d     = stall_q;
        win_tag     = fu_tag(RB_index_bus, winner);
        null_err_d  = null_err_q | (|(valid_bus & null_hit));

        if (flush) begin
            ptr_d = '0;
        end else if (any_req) begin
            grant_d[winner]      = 1'b1;
            cdb_valid_d[win_tag] = 1'b1;
            cdb_data_d[32'(win_tag)*WORD_SIZE +: WORD_SIZE] = fu_data(data_bus, winner);
            ptr_d = (32'(winner) == FU_NUM - 1) ? '0 : fu_idx_t'(winner + 1'b1);
            if (($countones(req) > 1) && (stall_q != '1)) begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= '0;
            cdb_data_q  <= '0;
            cdb_valid_q <= '0;
            null_err_q  <= 1'b0;
            stall_q     <= '0;
            ptr_q       <= '0;
        end else begin
            grant_q     <= grant_d;
            cdb_data_q  <= cdb_data_d;
            cdb_valid_q <= cdb_valid_d;
            null_err_q  <= null_err_d;
            stall_q     <= stall_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant          = grant_q;
    assign CDB_data_data  = cdb_data_q;
    assign CDB_data_valid = cdb_valid_q;
    assign null_err       = null_err_q;
    assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a table of directed vectors, directed
// reset/saturation sequences, then random stimulus against a behavioural model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic [FU_NUM-1:0]             valid_bus;
    logic [FU_NUM*WORD_SIZE-1:0]   data_bus;
    logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus;
    logic                          flush;
    logic [FU_NUM-1:0]             grant;
    logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data;
    logic [RB_SIZE-1:0]            CDB_data_valid;
    logic                          null_err;
    logic [15:0]                   stall_cnt;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_bus      (valid_bus),
        .data_bus       (data_bus),
        .RB_index_bus   (RB_index_bus),
        .flush          (flush),
        .grant          (grant),
        .CDB_data_data  (CDB_data_data),
        .CDB_data_valid (CDB_data_valid),
        .null_err       (null_err),
        .stall_cnt      (stall_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [7:0] v,
                             input logic [255:0] d, input logic nul, input logic [15:0] st);
        check({tag, " grant"}, 256'(grant), 256'(g));
        check({tag, " cdb_valid"}, 256'(CDB_data_valid), 256'(v));
        check({tag, " cdb_data"}, CDB_data_data, d);
        check({tag, " null_err"}, 256'(null_err), 256'(nul));
        check({tag, " stall_cnt"}, 256'(stall_cnt), 256'(st));
    endtask

    // Table data pattern: row number, FU index, fixed low half.
    function automatic logic [31:0] td(input int r, input int i);
        return {8'(r), 8'(i), 16'h1234};
    endfunction

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] tags;
        logic        fl;
        logic [3:0]  g;
        logic [7:0]  v;
        logic        nul;
        logic [15:0] st;
    } vec_t;

    // FU3..FU0 tags: normal = {3,5,2,1}; with FU0 carrying the NULL tag 7.
    localparam logic [11:0] TN = {3'd3, 3'd5, 3'd2, 3'd1};
    localparam logic [11:0] TZ = {3'd3, 3'd5, 3'd2, 3'd7};

    vec_t tbl [16];

    // Behavioural model state.
    logic [3:0]   m_grant;
    logic [7:0]   m_v;
    logic [255:0] m_d;
    logic         m_null;
    int           m_ptr;
    int           m_stall;

    task automatic model_reset();
        m_grant = '0; m_v = '0; m_d = '0; m_null = 1'b0; m_ptr = 0; m_stall = 0;
    endtask

    task automatic model_step();
        bit   elig [4];
        int   cnt;
        int   w;
        int   c;
        int   t;
        logic [3:0] g_prev;
        g_prev = m_grant;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            t = int'(RB_index_bus[i*3 +: 3]);
            if (valid_bus[i] && t == 7) m_null = 1'b1;
            elig[i] = valid_bus[i] && !g_prev[i] && t != 7;
            if (elig[i]) cnt++;
        end
        m_grant = '0; m_v = '0; m_d = '0;
        if (flush) begin
            m_ptr = 0;
        end else if (cnt > 0) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (w < 0 && elig[c]) w = c;
            end
            t = int'(RB_index_bus[w*3 +: 3]);
            m_grant[w] = 1'b1;
            m_v[t] = 1'b1;
            m_d[t*32 +: 32] = data_bus[w*32 +: 32];
            m_ptr = (w + 1) % 4;
            if (cnt > 1 && m_stall < 65535) m_stall++;
        end
    endtask

    initial begin
        logic [255:0] exp_d;
        int w, s;

        tbl[0]  = '{4'b0100, TN, 1'b0, 4'b0100, 8'h20, 1'b0, 16'd0};
        tbl[1]  = '{4'b0000, TN, 1'b0, 4'b0000, 8'h00, 1'b0, 16'd0};
        tbl[2]  = '{4'b1011, TN, 1'b0, 4'b1000, 8'h08, 1'b0, 16'd1};
        tbl[3]  = '{4'b0011, TN, 1'b0, 4'b0001, 8'h02, 1'b0, 16'd2};
        tbl[4]  = '{4'b1010, TN, 1'b0, 4'b0010, 8'h04, 1'b0, 16'd3};
        tbl[5]  = '{4'b1001, TN, 1'b0, 4'b1000, 8'h08, 1'b0, 16'd4};
        tbl[6]  = '{4'b0010, TN, 1'b0, 4'b0010, 8'h04, 1'b0, 16'd4};
        tbl[7]  = '{4'b0010, TN, 1'b0, 4'b0000, 8'h00, 1'b0, 16'd4};
        tbl[8]  = '{4'b0010, TN, 1'b0, 4'b0010, 8'h04, 1'b0, 16'd4};
        tbl[9]  = '{4'b0000, TN, 1'b0, 4'b0000, 8'h00, 1'b0, 16'd4};
        tbl[10] = '{4'b0001, TZ, 1'b0, 4'b0000, 8'h00, 1'b1, 16'd4};
        tbl[11] = '{4'b0101, TZ, 1'b0, 4'b0100, 8'h20, 1'b1, 16'd4};
        tbl[12] = '{4'b0001, TZ, 1'b0, 4'b0000, 8'h00, 1'b1, 16'd4};
        tbl[13] = '{4'b0101, TN, 1'b1, 4'b0000, 8'h00, 1'b1, 16'd4};
        tbl[14] = '{4'b0101, TN, 1'b0, 4'b0001, 8'h02, 1'b1, 16'd5};
        tbl[15] = '{4'b0100, TN, 1'b0, 4'b0100, 8'h20, 1'b1, 16'd5};

        reset_n = 1'b0; valid_bus = '0; data_bus = '0; RB_index_bus = TN; flush = 1'b0;
        #12;
        check_all("reset", 4'b0, 8'h0, 256'h0, 1'b0, 16'd0);
        reset_n = 1'b1;

        // Directed table.
        for (int r = 0; r < 16; r++) begin
            valid_bus = tbl[r].valid;
            RB_index_bus = tbl[r].tags;
            flush = tbl[r].fl;
            for (int i = 0; i < 4; i++) data_bus[i*32 +: 32] = td(r, i);
            @(posedge clk); #1;
            exp_d = '0;
            w = 0; s = 0;
            for (int i = 0; i < 4; i++) if (tbl[r].g[i]) w = i;
            for (int i = 0; i < 8; i++) if (tbl[r].v[i]) s = i;
            if (tbl[r].v != 0) exp_d[s*32 +: 32] = td(r, w);
            check_all($sformatf("row%0d", r), tbl[r].g, tbl[r].v, exp_d, tbl[r].nul, tbl[r].st);
        end

        // Asynchronous reset while FU1 holds the grant.
        valid_bus = 4'b0010; RB_index_bus = TN; flush = 1'b0;
        for (int i = 0; i < 4; i++) data_bus[i*32 +: 32] = td(20, i);
        @(posedge clk); #1;
        exp_d = '0; exp_d[2*32 +: 32] = td(20, 1);
        check_all("pre_reset", 4'b0010, 8'h04, exp_d, 1'b1, 16'd5);
        #3 reset_n = 1'b0;
        #1 check_all("async_reset", 4'b0, 8'h0, 256'h0, 1'b0, 16'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_all("rerequest", 4'b0010, 8'h04, exp_d, 1'b0, 16'd0);

        // Saturation: all four FUs requesting keeps every cycle contended.
        valid_bus = 4'b1111;
        for (int n = 0; n < 65534; n++) @(posedge clk);
        #1 check("stall_fffe", 256'(stall_cnt), 256'(16'hFFFE));
        for (int n = 0; n < 6; n++) @(posedge clk);
        #1 check("stall_sat", 256'(stall_cnt), 256'(16'hFFFF));

        // Random phase against the model.
        reset_n = 1'b0; valid_bus = '0; flush = 1'b0;
        #2 check("rand_reset_stall", 256'(stall_cnt), 256'h0);
        reset_n = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            valid_bus = 4'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 4; i++) begin
                data_bus[i*32 +: 32] = $urandom;
                RB_index_bus[i*3 +: 3] = ($urandom_range(0, 39) == 0) ? 3'd7
                                                                     : 3'($urandom_range(0, 6));
            end
            @(posedge clk);
            model_step();
            #1;
            check_all($sformatf("rand%0d", n), m_grant, m_v, m_d, m_null, 16'(m_stall));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
